// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding and frame parameters.
package imem_loader_pkg;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [7:0]  CHK_INIT       = 8'h00;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  im_we;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic [31:0]           im_wdata;

    modport slave  (input  in_valid, in_data,
                    output in_ready, im_we, im_addr, im_wdata);
    modport master (output in_valid, in_data,
                    input  in_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte of a word lands in [31:24].
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_full
);
    logic [1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift) begin
            word <= {word[23:0], din};
            cnt  <= cnt + 2'd1;
        end
    end

    // High while the next shifted byte completes the word; the counter wraps back to 0.
    assign word_full = (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (length, words, XOR checksum) into instruction RAM
// while holding the CPU in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int START_ADDR = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);
    localparam logic [31:0]           MAX_WORDS = 32'((64'd1 << ADDR_WIDTH) - 64'(START_ADDR));
    localparam logic [ADDR_WIDTH-1:0] ADDR0     = ADDR_WIDTH'(START_ADDR);

    logic [2:0]            state;
    logic [15:0]           remaining;
    logic [7:0]            chk;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic                  rdy;
    logic                  hs;
    logic                  start_ok;
    logic [15:0]           len_full;
    logic [31:0]           pk_word;
    logic                  pk_full;

    assign hs       = bus.in_valid && rdy;
    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign len_full = {remaining[15:8], bus.in_data};

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_ok),
        .shift     (hs && state == S_DATA),
        .din       (bus.in_data),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            chk       <= CHK_INIT;
            addr      <= ADDR0;
            we        <= 1'b0;
            rdy       <= 1'b0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LEN_HI;
                        rdy      <= 1'b1;
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                        addr     <= ADDR0;
                        chk      <= CHK_INIT;
                    end else if (state == S_DONE) begin
                        state <= S_IDLE;
                    end
                end
                S_LEN_HI: if (hs) begin
                    remaining[15:8] <= bus.in_data;
                    state           <= S_LEN_LO;
                end
                S_LEN_LO: if (hs) begin
                    remaining <= len_full;
                    if (len_full == 16'd0) begin
                        state <= S_CHECK;
                    end else if ({16'h0, len_full} > MAX_WORDS) begin
                        state <= S_ERROR;
                        rdy   <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: if (hs) begin
                    chk <= chk ^ bus.in_data;
                    if (pk_full) begin
                        state <= S_WRITE;
                        rdy   <= 1'b0;
                        we    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    remaining <= remaining - 16'd1;
                    rdy       <= 1'b1;
                    // Last word keeps its address so a full-depth load never wraps.
                    if (remaining == 16'd1) begin
                        state <= S_CHECK;
                    end else begin
                        state <= S_DATA;
                        addr  <= addr + ADDR_WIDTH'(1);
                    end
                end
                S_CHECK: if (hs) begin
                    rdy <= 1'b0;
                    if (bus.in_data == chk) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = rdy;
    assign bus.im_we    = we;
    assign bus.im_addr  = addr;
    assign bus.im_wdata = pk_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed tests for imem_loader: framing, checksum, length limits, mid-load start and reset.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset, start;
    logic cpu_hold, done, err;
    int   total = 0, bad = 0;
    int   wr_cnt = 0, done_cnt = 0, we_rdy_bad = 0;
    logic [7:0]  last_addr = 8'h00;
    logic [31:0] ram [256];

    imem_loader_if #(.ADDR_WIDTH(8)) bus ();

    imem_loader #(.ADDR_WIDTH(8), .START_ADDR(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // RAM model and event counters, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.im_we) begin
            ram[bus.im_addr] = bus.im_wdata;
            wr_cnt++;
            last_addr = bus.im_addr;
        end
        if (bus.im_we && bus.in_ready) we_rdy_bad++;
        if (done) done_cnt++;
    end

    function automatic logic [7:0] xsum(input logic [31:0] w[]);
        logic [7:0] c = 8'h00;
        foreach (w[i]) c ^= w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
        return c;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int   waitc = 0;
        logic took  = 1'b0;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(gap)) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!took && waitc < 50) begin
            took = bus.in_ready;
            @(negedge clk);
            waitc++;
        end
        bus.in_valid = 1'b0;
        if (!took) begin
            total++; bad++;
            $display("FAIL send_byte timeout: byte %h not accepted in 50 cycles", b);
        end
    endtask

    task automatic send_frame(input logic [31:0] w[], input logic [7:0] chk, input int gap);
        logic [15:0] n = 16'(w.size());
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        foreach (w[i]) for (int k = 3; k >= 0; k--) send_byte(w[i][8*k +: 8], gap);
        send_byte(chk, gap);
    endtask

    task automatic test_reset();
        total++;
        if ({bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, cpu_hold, done, err} !== 45'h0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b, want all 0",
                     bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, cpu_hold, done, err);
        end
    endtask

    // Frame A: N=2, 12345678 9ABCDEF0; XOR of all eight data bytes is 0x00.
    task automatic test_basic();
        int w0 = wr_cnt, d0 = done_cnt;
        pulse_start();
        total++;
        if (cpu_hold !== 1'b1) begin bad++; $display("FAIL basic_hold_after_start: got %b want 1", cpu_hold); end
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
        total++;
        if ({bus.im_we, bus.im_addr, bus.im_wdata, bus.in_ready} !== {1'b1, 8'h00, 32'h12345678, 1'b0}) begin
            bad++;
            $display("FAIL basic_word0: got we=%b addr=%h data=%h rdy=%b want 1 00 12345678 0",
                     bus.im_we, bus.im_addr, bus.im_wdata, bus.in_ready);
        end
        send_byte(8'h9A, 0); send_byte(8'hBC, 0); send_byte(8'hDE, 0); send_byte(8'hF0, 0);
        total++;
        if ({bus.im_we, bus.im_addr, bus.im_wdata, cpu_hold} !== {1'b1, 8'h01, 32'h9ABCDEF0, 1'b1}) begin
            bad++;
            $display("FAIL basic_word1: got we=%b addr=%h data=%h hold=%b want 1 01 9abcdef0 1",
                     bus.im_we, bus.im_addr, bus.im_wdata, cpu_hold);
        end
        send_byte(8'h00, 0);
        total++;
        if ({done, cpu_hold, err} !== 3'b100) begin
            bad++; $display("FAIL basic_done: got done/hold/err=%b want 100", {done, cpu_hold, err});
        end
        @(negedge clk);
        total++;
        if ({done, wr_cnt - w0, done_cnt - d0, bus.im_addr} !== {1'b0, 32'd2, 32'd1, 8'h01}) begin
            bad++;
            $display("FAIL basic_counts: got done=%b writes=%0d dones=%0d addr=%h want 0 2 1 01",
                     done, wr_cnt - w0, done_cnt - d0, bus.im_addr);
        end
    endtask

    task automatic test_bad_chk();
        logic [31:0] fa[];
        int w0, d0;
        fa = new[2]; fa[0] = 32'h12345678; fa[1] = 32'h9ABCDEF0;
        w0 = wr_cnt; d0 = done_cnt;
        pulse_start();
        send_frame(fa, 8'h09, 0);
        repeat (3) @(negedge clk);
        total++;
        if ({err, cpu_hold, wr_cnt - w0, done_cnt - d0} !== {1'b1, 1'b1, 32'd2, 32'd0}) begin
            bad++;
            $display("FAIL badchk_error: got err=%b hold=%b writes=%0d dones=%0d want 1 1 2 0",
                     err, cpu_hold, wr_cnt - w0, done_cnt - d0);
        end
        pulse_start();
        total++;
        if ({err, cpu_hold} !== 2'b01) begin
            bad++; $display("FAIL badchk_restart: got err/hold=%b want 01", {err, cpu_hold});
        end
        send_frame(fa, xsum(fa), 0);
        total++;
        if ({done, cpu_hold, err} !== 3'b100) begin
            bad++; $display("FAIL badchk_reload: got done/hold/err=%b want 100", {done, cpu_hold, err});
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] fz[];
        int w0 = wr_cnt, d0;
        fz = new[0];
        pulse_start();
        send_frame(fz, 8'h00, 0);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
        d0 = done_cnt;
        @(negedge clk);
        total++;
        if ({wr_cnt - w0, done_cnt - d0, cpu_hold, err} !== {32'd0, 32'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL zero_counts: got writes=%0d dones=%0d hold=%b err=%b want 0 1 0 0",
                     wr_cnt - w0, done_cnt - d0, cpu_hold, err);
        end
    endtask

    task automatic test_overflow();
        int w0 = wr_cnt;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        total++;
        if ({err, cpu_hold, bus.in_ready} !== 3'b110) begin
            bad++; $display("FAIL ovf_error: got err/hold/rdy=%b want 110", {err, cpu_hold, bus.in_ready});
        end
        repeat (4) @(negedge clk);
        total++;
        if ({wr_cnt - w0, bus.in_ready, err} !== {32'd0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL ovf_nowrite: got writes=%0d rdy=%b err=%b want 0 0 1", wr_cnt - w0, bus.in_ready, err);
        end
    endtask

    task automatic test_full();
        logic [31:0] w[];
        int w0 = wr_cnt, miss = 0;
        w = new[256];
        foreach (w[i]) w[i] = {8'(i), ~8'(i), 8'(i * 3), 8'hC3};
        foreach (ram[i]) ram[i] = 32'h0;
        pulse_start();
        send_frame(w, xsum(w), 0);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL full_done: got %b want 1", done); end
        @(negedge clk);
        foreach (w[i]) if (ram[i] !== w[i]) miss++;
        total++;
        if ({wr_cnt - w0, last_addr, bus.im_addr, miss} !== {32'd256, 8'hFF, 8'hFF, 32'd0}) begin
            bad++;
            $display("FAIL full_load: got writes=%0d last=%h addr=%h bad_words=%0d want 256 ff ff 0",
                     wr_cnt - w0, last_addr, bus.im_addr, miss);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] fa[];
        int w0, d0, r0;
        fa = new[2]; fa[0] = 32'h12345678; fa[1] = 32'h9ABCDEF0;
        ram[0] = 32'h0; ram[1] = 32'h0;
        w0 = wr_cnt; r0 = we_rdy_bad;
        pulse_start();
        fork
            send_frame(fa, xsum(fa), 2);
            begin
                repeat (8) @(negedge clk);
                pulse_start();
            end
        join
        total++;
        if ({done, err} !== 2'b10) begin bad++; $display("FAIL gaps_done: got done/err=%b want 10", {done, err}); end
        d0 = done_cnt;
        @(negedge clk);
        total++;
        if ({ram[0], ram[1], wr_cnt - w0, done_cnt - d0, we_rdy_bad - r0} !==
            {32'h12345678, 32'h9ABCDEF0, 32'd2, 32'd1, 32'd0}) begin
            bad++;
            $display("FAIL gaps_data: got %h %h writes=%0d dones=%0d rdy_in_write=%0d want 12345678 9abcdef0 2 1 0",
                     ram[0], ram[1], wr_cnt - w0, done_cnt - d0, we_rdy_bad - r0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] fb[];
        fb = new[2]; fb[0] = 32'hCAFEBABE; fb[1] = 32'h01020304;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'hAB, 0);
        #2 reset = 1'b1;
        #1 test_reset();
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        send_frame(fb, xsum(fb), 0);
        total++;
        if ({done, err} !== 2'b10) begin bad++; $display("FAIL rstmid_done: got done/err=%b want 10", {done, err}); end
        @(negedge clk);
        total++;
        if ({ram[0], ram[1], last_addr} !== {32'hCAFEBABE, 32'h01020304, 8'h01}) begin
            bad++;
            $display("FAIL rstmid_reload: got %h %h last=%h want cafebabe 01020304 01", ram[0], ram[1], last_addr);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_bad_chk();
        test_zero_len();
        test_overflow();
        test_full();
        test_gaps();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
